// File: rtl/norm_pipeline.sv
// norm_pipeline: per-frame pixel normaliser, out = sat(pix * floor(((2^PIX_W-1) << FRAC_W) / D) >> FRAC_W).
// A sequential restoring divider computes the reciprocal coefficient once per frame, then a two-stage
// multiply/scale pipeline feeds a first-word-fall-through output FIFO under credit-based flow control.
// Optional feature macro: NORM_PIPELINE_ROUND_EN (round half up in stage 2 instead of truncating).
module norm_pipeline #(
    parameter int PIX_W      = 8,
    parameter int FRAC_W     = 16,
    parameter int OUT_ROWS   = 10,
    parameter int OUT_COLS   = 10,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             ap_start,
    output logic             ap_ready,
    output logic             ap_done,
    input  logic             cf_ap_done,
    input  logic [PIX_W-1:0] norm_denominator,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic [PIX_W-1:0] s_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [PIX_W-1:0] m_axis_tdata,
    output logic             m_axis_tlast
);

    localparam int QW  = PIX_W + FRAC_W;
    localparam int PW  = PIX_W + QW;
    localparam int N   = OUT_ROWS * OUT_COLS;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(N + 1);
    localparam int DCW = $clog2(QW);

    localparam logic [QW-1:0]    DIVIDEND = {{PIX_W{1'b1}}, {FRAC_W{1'b0}}};
    localparam logic [PIX_W-1:0] MAX_PIX  = {PIX_W{1'b1}};
`ifdef NORM_PIPELINE_ROUND_EN
    localparam logic [PW:0]      RND_TERM = (PW + 1)'(1) << (FRAC_W - 1);
`else
    localparam logic [PW:0]      RND_TERM = '0;
`endif

    typedef enum logic [2:0] {IDLE, CALC, WAIT_UP, RUN, DONE} state_t;
    state_t state, state_next;

    logic [PIX_W-1:0] den;
    logic [QW-1:0]    div_q;
    logic [PIX_W-1:0] rem;
    logic [DCW-1:0]   div_cnt;
    logic [QW-1:0]    coef;
    logic             up_done;
    logic [CW-1:0]    in_cnt;
    logic [CW-1:0]    out_cnt;

    logic             s1_valid;
    logic [PW-1:0]    s1_prod;
    logic             s2_valid;
    logic [PIX_W-1:0] s2_data;

    logic [PIX_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      fifo_count;
    logic             fifo_empty;

    logic             start_accept;
    logic             in_hs;
    logic             out_hs;
    logic             frame_last;
    logic             div_last;
    logic [PIX_W:0]   trial;
    logic [PIX_W:0]   diff;
    logic             sub_ok;
    logic [QW-1:0]    q_next;
    logic [PW:0]      rnd_sum;
    logic [PW:0]      shifted;
    logic [PIX_W-1:0] s2_next;
    logic [AW+1:0]    occupancy;
    logic             credit_ok;

    // One restoring-divider step: the borrow bit of trial-D decides the quotient bit.
    always_comb begin
        trial  = {rem, div_q[QW-1]};
        diff   = trial - {1'b0, den};
        sub_ok = !diff[PIX_W];
        q_next = {div_q[QW-2:0], sub_ok};
    end

    // Stage-2 scaling: optional rounding term, drop fractional bits, clamp to the pixel range.
    always_comb begin
        rnd_sum = {1'b0, s1_prod} + RND_TERM;
        shifted = rnd_sum >> FRAC_W;
        s2_next = (|shifted[PW:PIX_W]) ? MAX_PIX : shifted[PIX_W-1:0];
    end

    // Handshakes, FIFO status and the credit check that keeps the never-stalling pipeline from overflowing the FIFO.
    always_comb begin
        start_accept  = (state == IDLE) && ap_start;
        div_last      = (div_cnt == DCW'(QW - 1));
        fifo_count    = wr_ptr - rd_ptr;
        fifo_empty    = (fifo_count == '0);
        m_axis_tvalid = !fifo_empty;
        m_axis_tdata  = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];
        frame_last    = (out_cnt == CW'(N - 1));
        m_axis_tlast  = m_axis_tvalid && frame_last;
        occupancy     = {1'b0, fifo_count} + (AW + 2)'(s1_valid) + (AW + 2)'(s2_valid);
        credit_ok     = (in_cnt < CW'(N)) && (occupancy < (AW + 2)'(FIFO_DEPTH));
        in_hs         = s_axis_tvalid && s_axis_tready;
        out_hs        = m_axis_tvalid && m_axis_tready;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) state <= IDLE;
        else      state <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ap_start) state_next = CALC;
            CALC:    if (div_last) state_next = WAIT_UP;
            WAIT_UP: if (up_done) state_next = RUN;
            RUN:     if (out_hs && frame_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        ap_ready      = (state == IDLE);
        ap_done       = (state == DONE);
        s_axis_tready = (state == RUN) && credit_ok;
    end

    // Denominator capture and the coefficient divider, one quotient bit per CALC cycle.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            den     <= '0;
            div_q   <= '0;
            rem     <= '0;
            div_cnt <= '0;
            coef    <= '0;
        end else if (start_accept) begin
            den     <= (norm_denominator == '0) ? PIX_W'(1) : norm_denominator;
            div_q   <= DIVIDEND;
            rem     <= '0;
            div_cnt <= '0;
        end else if (state == CALC) begin
            div_q   <= q_next;
            rem     <= sub_ok ? diff[PIX_W-1:0] : trial[PIX_W-1:0];
            div_cnt <= div_cnt + DCW'(1);
            if (div_last) coef <= q_next;
        end
    end

    // Sticky record of the upstream frame-complete pulse, even if it arrives while still dividing.
    always_ff @(posedge clk or posedge srst) begin
        if (srst)                              up_done <= 1'b0;
        else if (start_accept)                 up_done <= 1'b0;
        else if (cf_ap_done && state != IDLE)  up_done <= 1'b1;
    end

    // Frame-position counters for accepted input pixels and delivered output pixels.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if (start_accept) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (in_hs)  in_cnt  <= in_cnt + CW'(1);
            if (out_hs) out_cnt <= out_cnt + CW'(1);
        end
    end

    // Two-stage multiply/scale pipeline; it never stalls, so valids simply shift along.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            s1_valid <= in_hs;
            if (in_hs) s1_prod <= PW'(s_axis_tdata) * PW'(coef);
            s2_valid <= s1_valid;
            if (s1_valid) s2_data <= s2_next;
        end
    end

    // FIFO storage; contents need no reset because emptiness is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (s2_valid) mem[wr_ptr[AW-1:0]] <= s2_data;
    end

    // FIFO pointers with a wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (s2_valid) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (out_hs)   rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

endmodule

// File: tb/tb_norm_pipeline.sv
// tb_norm_pipeline: scoreboard bench for norm_pipeline (8-bit pixels, 16 fractional bits, 10x10, FIFO 16).
// Drivers push hand-computed expected pixels into a queue; an independent monitor pops and compares.
module tb_norm_pipeline;

    logic       clk = 1'b0;
    logic       srst;
    logic       ap_start;
    logic       ap_ready;
    logic       ap_done;
    logic       cf_ap_done;
    logic [7:0] norm_denominator;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic [7:0] s_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tlast;

`ifdef NORM_PIPELINE_ROUND_EN
    localparam logic [7:0] EXP_64_D128 = 8'd128;
`else
    localparam logic [7:0] EXP_64_D128 = 8'd127;
`endif

    int         n_tests = 0;
    int         n_fail = 0;
    logic [8:0] exp_q [$];
    int         out_seen = 0;
    int         in_seen = 0;
    int         done_cnt = 0;
    int         done_base = 0;
    bit         abort = 1'b0;
    bit         hold_valid = 1'b0;
    logic [7:0] hold_data = '0;

    norm_pipeline #(
        .PIX_W(8), .FRAC_W(16), .OUT_ROWS(10), .OUT_COLS(10), .FIFO_DEPTH(16)
    ) dut (
        .clk(clk), .srst(srst),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .cf_ap_done(cf_ap_done),
        .norm_denominator(norm_denominator),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("[TB] FAIL %s: timed out, got no event, expected one", name);
    endtask

    // Monitor: scoreboard pops on each output handshake, plus hold-stability and pulse counting.
    always @(negedge clk) begin
        logic [8:0] e;
        if (srst) begin
            hold_valid = 1'b0;
        end else begin
            if (ap_done) done_cnt++;
            if (s_axis_tvalid && s_axis_tready) in_seen++;
            if (hold_valid) begin
                check_output("hold_valid", 32'(m_axis_tvalid), 32'd1);
                check_output("hold_data", 32'(m_axis_tdata), 32'(hold_data));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_output: got data %0d, expected no output", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check_output("out_data", 32'(m_axis_tdata), 32'(e[7:0]));
                    check_output("out_last", 32'(m_axis_tlast), 32'(e[8]));
                end
                out_seen++;
                hold_valid = 1'b0;
            end else if (m_axis_tvalid) begin
                hold_valid = 1'b1;
                hold_data  = m_axis_tdata;
            end else begin
                hold_valid = 1'b0;
            end
        end
    end

    // Offer one pixel until accepted (or aborted) and queue its expected output.
    task automatic apply_stimulus(input logic [7:0] pix, input logic [8:0] expv);
        int  budget = 0;
        bit  fin = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = pix;
        while (!fin) begin
            @(negedge clk);
            if (abort) begin
                fin = 1'b1;
            end else if (s_axis_tready) begin
                @(posedge clk);
                #1;
                exp_q.push_back(expv);
                fin = 1'b1;
            end else begin
                budget++;
                if (budget > 1000) begin
                    fail_now("input_accept");
                    abort = 1'b1;
                    fin = 1'b1;
                end
            end
        end
    endtask

    task automatic start_frame(input logic [7:0] den);
        int budget = 0;
        @(negedge clk);
        while (!ap_ready && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        if (!ap_ready) fail_now("ap_ready_wait");
        done_base        = done_cnt;
        norm_denominator = den;
        ap_start         = 1'b1;
        @(posedge clk);
        #1;
        ap_start = 1'b0;
    endtask

    task automatic pulse_cf();
        @(negedge clk);
        cf_ap_done = 1'b1;
        @(negedge clk);
        cf_ap_done = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int budget = 0;
        while (done_cnt == done_base && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        if (done_cnt == done_base) fail_now(name);
        repeat (5) @(negedge clk);
        check_output({name, "_pulses"}, 32'(done_cnt - done_base), 32'd1);
        check_output({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_ap_ready"}, 32'(ap_ready), 32'd1);
        check_output({tag, "_ap_done"}, 32'(ap_done), 32'd0);
        check_output({tag, "_s_tready"}, 32'(s_axis_tready), 32'd0);
        check_output({tag, "_m_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        check_output({tag, "_m_tlast"}, 32'(m_axis_tlast), 32'd0);
        check_output({tag, "_m_tdata"}, 32'(m_axis_tdata), 32'd0);
    endtask

    // Directed sequence of frames.
    initial begin
        logic [7:0] pix_tab [4];
        logic [7:0] exp_tab [4];
        bit         seen;
        int         in_base;
        int         out_base;
        int         budget;

        srst = 1'b1; ap_start = 1'b0; cf_ap_done = 1'b0; norm_denominator = '0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        srst = 1'b0;

        // D=255 gives unity gain; upstream done arrives while the divider is still busy.
        start_frame(8'd255);
        repeat (3) @(negedge clk);
        pulse_cf();
        for (int i = 0; i < 100; i++) apply_stimulus(8'(i), {(i == 99), 8'(i)});
        s_axis_tvalid = 1'b0;
        wait_done("frame_d255");
        check_output("coef_d255", 32'(dut.coef), 32'd65536);

        // D=128 with upstream done withheld: no input may be accepted until it comes.
        start_frame(8'd128);
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (s_axis_tready) seen = 1'b1;
        end
        check_output("tready_withheld", 32'(seen), 32'd0);
        pulse_cf();
        pix_tab = '{8'd64, 8'd200, 8'd0, 8'd255};
        exp_tab = '{EXP_64_D128, 8'd255, 8'd0, 8'd255};
        for (int i = 0; i < 100; i++) apply_stimulus(pix_tab[i % 4], {(i == 99), exp_tab[i % 4]});
        s_axis_tvalid = 1'b0;
        wait_done("frame_d128");
        check_output("coef_d128", 32'(dut.coef), 32'd130560);

        // D=0 is treated as 1: any non-zero pixel saturates.
        start_frame(8'd0);
        pulse_cf();
        for (int i = 0; i < 100; i++) apply_stimulus(8'(i % 2), {(i == 99), ((i % 2) == 1) ? 8'd255 : 8'd0});
        s_axis_tvalid = 1'b0;
        wait_done("frame_d0");
        check_output("coef_d0", 32'(dut.coef), 32'd16711680);

        // Output back-pressure for 40 cycles with continuous input: exactly a FIFO's worth is buffered.
        m_axis_tready = 1'b0;
        start_frame(8'd255);
        pulse_cf();
        in_base = in_seen;
        fork
            begin
                for (int i = 0; i < 100; i++) apply_stimulus(8'((i * 7) % 256), {(i == 99), 8'((i * 7) % 256)});
                s_axis_tvalid = 1'b0;
            end
            begin
                budget = 0;
                while (in_seen == in_base && budget < 200) begin
                    @(negedge clk);
                    budget++;
                end
                if (in_seen == in_base) fail_now("bp_first_accept");
                repeat (40) @(negedge clk);
                check_output("bp_buffered", 32'(in_seen - in_base), 32'd16);
                check_output("bp_tready_low", 32'(s_axis_tready), 32'd0);
                check_output("bp_tvalid_high", 32'(m_axis_tvalid), 32'd1);
                m_axis_tready = 1'b1;
            end
        join
        wait_done("frame_bp");

        // Reset after 50 outputs: everything in flight is discarded.
        start_frame(8'd255);
        pulse_cf();
        out_base = out_seen;
        fork
            begin
                for (int i = 0; i < 100 && !abort; i++) apply_stimulus(8'(i + 50), {(i == 99), 8'(i + 50)});
                s_axis_tvalid = 1'b0;
            end
            begin
                budget = 0;
                while ((out_seen - out_base) < 50 && budget < 1000) begin
                    @(negedge clk);
                    budget++;
                end
                if ((out_seen - out_base) < 50) fail_now("midreset_outputs");
                abort = 1'b1;
                #2;
                srst = 1'b1;
                #1;
                check_reset_outputs("midreset");
                repeat (3) @(negedge clk);
                exp_q.delete();
                srst = 1'b0;
            end
        join
        abort = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (m_axis_tvalid) seen = 1'b1;
        end
        check_output("post_reset_quiet", 32'(seen), 32'd0);

        start_frame(8'd255);
        pulse_cf();
        for (int i = 0; i < 100; i++) apply_stimulus(8'(255 - i), {(i == 99), 8'(255 - i)});
        s_axis_tvalid = 1'b0;
        wait_done("frame_after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
